// File: rtl/hpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hpu_pkg
// Brief    : Shared types and default widths for the run sequencer slice.
// Revision : 1.0 - initial release
// ============================================================================
package hpu_pkg;

  localparam int COM_LEN_W_DEF = 8;
  localparam int DAT_LEN_W_DEF = 16;
  localparam int DRAIN_CYC_DEF = 4;

  // Job phases, explicitly encoded so waveforms read the same across builds.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    COM   = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    PUT   = 3'd4
  } seq_state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/run_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : run_sequencer_if
// Brief    : Host job request, inbound stream and result handshake bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface run_sequencer_if
  import hpu_pkg::*;
#(
  parameter int COM_LEN_W = COM_LEN_W_DEF,
  parameter int DAT_LEN_W = DAT_LEN_W_DEF
);

  logic                 start;
  logic [COM_LEN_W-1:0] com_len;
  logic [DAT_LEN_W-1:0] dat_len;
  logic                 get_valid;
  logic                 get_ready;
  logic                 com;
  logic                 run;
  logic                 get_c;
  logic                 get_v;
  logic                 exec;
  logic                 put_valid;
  logic                 put_ready;
  logic                 busy;
  logic                 done;

  // Host / stream source side
  modport master (
    output start, com_len, dat_len, get_valid, put_ready,
    input  get_ready, com, run, get_c, get_v, exec, put_valid, busy, done
  );

  // Sequencer side
  modport slave (
    input  start, com_len, dat_len, get_valid, put_ready,
    output get_ready, com, run, get_c, get_v, exec, put_valid, busy, done
  );

endinterface
`default_nettype wire

// File: rtl/beat_counter.sv
`default_nettype none
// ============================================================================
// Module   : beat_counter
// Brief    : Clearable beat counter with terminal-count detect. The compare is
//            made on count+1 so an all-ones terminal completes without wrap.
// Revision : 1.0 - initial release
// ============================================================================
module beat_counter #(
  parameter int WIDTH = 16
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             clear,
  input  wire logic             enable,
  input  wire logic [WIDTH-1:0] terminal,
  output logic                  last
);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_inc;

  assign w_count_inc = r_count + WIDTH'(1);
  assign last        = enable && (w_count_inc == terminal);

  // Count enabled beats; self-clear on the terminal beat so the next phase starts at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (clear || last) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= w_count_inc;
    end
  end

endmodule
`default_nettype wire

// File: rtl/run_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : run_sequencer
// Brief    : Job sequencer: accepts com words, then run words, drains the
//            datapath pipeline and presents a result handshake to the host.
// Revision : 1.0 - initial release
// ============================================================================
module run_sequencer
  import hpu_pkg::*;
#(
  parameter int COM_LEN_W = COM_LEN_W_DEF,
  parameter int DAT_LEN_W = DAT_LEN_W_DEF,
  parameter int DRAIN_CYC = DRAIN_CYC_DEF
) (
  input  wire logic      clk,
  input  wire logic      rst,
  run_sequencer_if.slave bus
);

  // One counter serves both beat phases and the drain, so it is as wide as
  // the wider length field.
  localparam int              CNT_W         = max2(COM_LEN_W, DAT_LEN_W);
  localparam logic [CNT_W-1:0] c_drain_term = CNT_W'(DRAIN_CYC);

  seq_state_t           r_state;
  seq_state_t           w_state_nxt;
  logic [COM_LEN_W-1:0] r_com_len;
  logic [DAT_LEN_W-1:0] r_dat_len;
  logic                 r_exec;
  logic                 r_done;

  logic                 w_get_ready;
  logic                 w_com;
  logic                 w_run;
  logic                 w_get_c;
  logic                 w_get_v;
  logic                 w_put_valid;
  logic                 w_busy;
  logic                 w_cnt_clear;
  logic                 w_cnt_en;
  logic [CNT_W-1:0]     w_cnt_term;
  logic                 w_cnt_last;

  assign w_get_c = bus.get_valid & w_get_ready & w_com;
  assign w_get_v = bus.get_valid & w_get_ready & w_run & ~w_com;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; zero-length phases are skipped straight from IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          if (bus.com_len != '0)      w_state_nxt = COM;
          else if (bus.dat_len != '0) w_state_nxt = RUN;
          else                        w_state_nxt = DRAIN;
        end
      end
      COM: begin
        if (w_get_c && w_cnt_last) w_state_nxt = (r_dat_len != '0) ? RUN : DRAIN;
      end
      RUN: begin
        if (w_get_v && w_cnt_last) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (w_cnt_last) w_state_nxt = PUT;
      end
      PUT: begin
        if (bus.put_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Phase outputs decoded from the current state only.
  always_comb begin
    w_get_ready = 1'b0;
    w_com       = 1'b0;
    w_run       = 1'b0;
    w_put_valid = 1'b0;
    w_busy      = 1'b1;
    case (r_state)
      IDLE:  w_busy = 1'b0;
      COM: begin
        w_get_ready = 1'b1;
        w_com       = 1'b1;
      end
      RUN: begin
        w_get_ready = 1'b1;
        w_run       = 1'b1;
      end
      PUT:   w_put_valid = 1'b1;
      default: ;
    endcase
  end

  // Counter steering: beats in COM/RUN, free-running cycles in DRAIN, held clear otherwise.
  always_comb begin
    w_cnt_clear = 1'b0;
    w_cnt_en    = 1'b0;
    w_cnt_term  = '0;
    case (r_state)
      COM: begin
        w_cnt_en   = w_get_c;
        w_cnt_term = CNT_W'(r_com_len);
      end
      RUN: begin
        w_cnt_en   = w_get_v;
        w_cnt_term = CNT_W'(r_dat_len);
      end
      DRAIN: begin
        w_cnt_en   = 1'b1;
        w_cnt_term = c_drain_term;
      end
      default: w_cnt_clear = 1'b1;
    endcase
  end

  beat_counter #(
    .WIDTH (CNT_W)
  ) u_beat_counter (
    .clk      (clk),
    .rst      (rst),
    .clear    (w_cnt_clear),
    .enable   (w_cnt_en),
    .terminal (w_cnt_term),
    .last     (w_cnt_last)
  );

  // Capture job lengths only on an accepted start; later starts leave them untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_com_len <= '0;
      r_dat_len <= '0;
    end else if ((r_state == IDLE) && bus.start) begin
      r_com_len <= bus.com_len;
      r_dat_len <= bus.dat_len;
    end
  end

  // Compute strobe trails each accepted run word by one cycle; done trails the result handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_exec <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_exec <= w_get_v;
      r_done <= w_put_valid & bus.put_ready;
    end
  end

  assign bus.get_ready = w_get_ready;
  assign bus.com       = w_com;
  assign bus.run       = w_run;
  assign bus.get_c     = w_get_c;
  assign bus.get_v     = w_get_v;
  assign bus.exec      = r_exec & w_busy;
  assign bus.put_valid = w_put_valid;
  assign bus.busy      = w_busy;
  assign bus.done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_run_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_run_sequencer
// Brief    : Self-checking bench for run_sequencer (table rows, corner
//            sequences and randomized jobs against a phase-timeline model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_run_sequencer;

  localparam int DRAIN = 4;
  localparam int MAXC  = 400;

  typedef struct {
    int c;
    int d;
    int vmode;
    int pdelay;
    int exp_put;
    int exp_com;
    int exp_run;
  } vec_t;

  logic clk;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   pat [1:MAXC];
  vec_t vecs [7];

  run_sequencer_if #(.COM_LEN_W(8), .DAT_LEN_W(16)) bus ();

  run_sequencer #(
    .COM_LEN_W (8),
    .DAT_LEN_W (16),
    .DRAIN_CYC (DRAIN)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " get_ready"}, int'(bus.get_ready), 0);
    check({tag, " com"},       int'(bus.com),       0);
    check({tag, " run"},       int'(bus.run),       0);
    check({tag, " get_c"},     int'(bus.get_c),     0);
    check({tag, " get_v"},     int'(bus.get_v),     0);
    check({tag, " exec"},      int'(bus.exec),      0);
    check({tag, " put_valid"}, int'(bus.put_valid), 0);
    check({tag, " busy"},      int'(bus.busy),      0);
    check({tag, " done"},      int'(bus.done),      0);
  endtask

  // get_valid pattern per cycle after start: 0 = always 1, 1 = 1,0,1,0..., 2 = random
  function automatic void fill_pat(input int mode);
    for (int i = 1; i <= MAXC; i++) begin
      case (mode)
        0:       pat[i] = 1'b1;
        1:       pat[i] = (i % 2) == 1;
        default: pat[i] = 1'($urandom_range(0, 1));
      endcase
    end
  endfunction

  // Cycle index (1-based after start) of the n-th offered word; 0 when n==0.
  function automatic int nth_one(input int n);
    int seen = 0;
    if (n == 0) return 0;
    for (int i = 1; i <= MAXC; i++) begin
      if (pat[i]) begin
        seen++;
        if (seen == n) return i;
      end
    end
    return -1;
  endfunction

  // One job: the model timeline is COM on cycles 1..exp_com, RUN on the next
  // exp_run cycles, put_valid first on exp_put.
  task automatic run_job(input string tag, input int c, input int d, input int pdelay,
                         input int exp_put, input int exp_com, input int exp_run);
    int n_c = 0;
    int n_v = 0;
    int put_cyc = -1;
    bit e_prev_v = 1'b0;
    bit hs = 1'b0;
    bit e_com, e_run, e_getv;
    @(posedge clk); #1;
    bus.start     = 1'b1;
    bus.com_len   = 8'(c);
    bus.dat_len   = 16'(d);
    bus.get_valid = 1'($urandom_range(0, 1));
    bus.put_ready = 1'b0;
    @(negedge clk);
    check({tag, " start-cycle busy"},      int'(bus.busy),      0);
    check({tag, " start-cycle get_ready"}, int'(bus.get_ready), 0);
    for (int cyc = 1; cyc <= exp_put + 20; cyc++) begin
      @(posedge clk); #1;
      bus.start     = ($urandom_range(0, 3) == 0);
      bus.com_len   = 8'($urandom);
      bus.dat_len   = 16'($urandom);
      bus.get_valid = pat[cyc];
      bus.put_ready = (pdelay == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      e_com  = (cyc <= exp_com);
      e_run  = (cyc > exp_com) && (cyc <= exp_com + exp_run);
      e_getv = e_run & pat[cyc];
      check($sformatf("%s c%0d com", tag, cyc),       int'(bus.com),       int'(e_com));
      check($sformatf("%s c%0d run", tag, cyc),       int'(bus.run),       int'(e_run));
      check($sformatf("%s c%0d get_ready", tag, cyc), int'(bus.get_ready), int'(e_com | e_run));
      check($sformatf("%s c%0d get_c", tag, cyc),     int'(bus.get_c),     int'(e_com & pat[cyc]));
      check($sformatf("%s c%0d get_v", tag, cyc),     int'(bus.get_v),     int'(e_getv));
      check($sformatf("%s c%0d exec", tag, cyc),      int'(bus.exec),      int'(e_prev_v));
      check($sformatf("%s c%0d busy", tag, cyc),      int'(bus.busy),      1);
      check($sformatf("%s c%0d put_valid", tag, cyc), int'(bus.put_valid), int'(cyc == exp_put));
      e_prev_v = e_getv;
      n_c += int'(bus.get_c);
      n_v += int'(bus.get_v);
      if (bus.put_valid) begin
        put_cyc = cyc;
        hs      = bus.put_ready;
        break;
      end
    end
    check({tag, " put cycle"},   put_cyc, exp_put);
    check({tag, " get_c total"}, n_c,     c);
    check({tag, " get_v total"}, n_v,     d);
    if (put_cyc > 0) begin
      if (!hs) begin
        for (int k = 0; k < pdelay; k++) begin
          @(posedge clk); #1;
          bus.start     = 1'b0;
          bus.put_ready = 1'b0;
          @(negedge clk);
          check($sformatf("%s hold%0d put_valid", tag, k), int'(bus.put_valid), 1);
          check($sformatf("%s hold%0d done", tag, k),      int'(bus.done),      0);
        end
        @(posedge clk); #1;
        bus.start     = 1'b0;
        bus.put_ready = 1'b1;
        @(negedge clk);
        check({tag, " handshake put_valid"}, int'(bus.put_valid), 1);
      end
      @(posedge clk); #1;
      bus.start     = 1'b0;
      bus.put_ready = 1'b0;
      bus.get_valid = 1'b0;
      @(negedge clk);
      check({tag, " done pulse"},     int'(bus.done),      1);
      check({tag, " idle busy"},      int'(bus.busy),      0);
      check({tag, " idle put_valid"}, int'(bus.put_valid), 0);
      @(posedge clk); #1;
      @(negedge clk);
      check({tag, " done cleared"}, int'(bus.done), 0);
    end
  endtask

  initial begin
    int c, d, lc, l;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.com_len   = '0;
    bus.dat_len   = '0;
    bus.get_valid = 1'b0;
    bus.put_ready = 1'b0;
    #3;
    check_all_zero("reset");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;

    //          c    d  vmode pdelay put  com  run
    vecs[0] = '{2,   3, 0,    0,     10,  2,   3};
    vecs[1] = '{0,   0, 0,    0,     5,   0,   0};
    vecs[2] = '{0,   5, 1,    0,     14,  0,   9};
    vecs[3] = '{1,   1, 0,    10,    7,   1,   1};
    vecs[4] = '{3,   0, 1,    2,     10,  5,   0};
    vecs[5] = '{255, 2, 0,    1,     262, 255, 2};
    vecs[6] = '{4,   2, 1,    0,     16,  7,   4};

    for (int i = 0; i < 7; i++) begin
      fill_pat(vecs[i].vmode);
      run_job($sformatf("vec%0d", i), vecs[i].c, vecs[i].d, vecs[i].pdelay,
              vecs[i].exp_put, vecs[i].exp_com, vecs[i].exp_run);
    end

    // Reset in the middle of RUN after two of five beats.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.com_len = 8'd0; bus.dat_len = 16'd5;
    bus.get_valid = 1'b1; bus.put_ready = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    check("midrun run", int'(bus.run),  1);
    check("midrun exec", int'(bus.exec), 1);
    #1;
    rst = 1'b1;
    #1;
    check_all_zero("async rst");
    @(posedge clk); #1;
    @(negedge clk);
    check_all_zero("held rst");
    @(posedge clk); #1;
    rst = 1'b0;
    bus.get_valid = 1'b0;
    fill_pat(0);
    run_job("post_rst", 0, 1, 0, 1 + DRAIN + 1, 0, 1);

    // Randomized jobs against the timeline model.
    for (int j = 0; j < 12; j++) begin
      c = $urandom_range(0, 5);
      d = $urandom_range(0, 8);
      fill_pat(2);
      lc = nth_one(c);
      l  = nth_one(c + d);
      run_job($sformatf("rnd%0d", j), c, d, $urandom_range(0, 3),
              ((c + d) == 0) ? (DRAIN + 1) : (l + DRAIN + 1), lc, l - lc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/run_sequencer.md
RUN_SEQUENCER -- requirements
Module: run_sequencer

Interface
REQ-001 Parameter COM_LEN_W, default 8, width of the com-phase word count.
REQ-002 Parameter DAT_LEN_W, default 16, width of the run-phase word count.
REQ-003 Parameter DRAIN_CYC, default 4, pipeline drain cycles after the last run beat (range 1..255).
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst  in  1  reset, asynchronous and active-high.
REQ-006 start  in  1  one-cycle job request from host.
REQ-007 com_len  in  COM_LEN_W  number of com (configuration) words in the job.
REQ-008 dat_len  in  DAT_LEN_W  number of run (data) words in the job.
REQ-009 get_valid  in  1  inbound stream word valid.
REQ-010 get_ready  out  1  inbound stream accept.
REQ-011 com  out  1  com phase active.
REQ-012 run  out  1  run phase active.
REQ-013 get_c  out  1  com word accepted this cycle.
REQ-014 get_v  out  1  run word accepted this cycle.
REQ-015 exec  out  1  datapath compute strobe.
REQ-016 put_valid  out  1  result available to host.
REQ-017 put_ready  in  1  host accepts result.
REQ-018 busy  out  1  job in progress (state not IDLE).
REQ-019 done  out  1  one-cycle job completion pulse.

Function
REQ-020 FSM states SHALL be IDLE, COM, RUN, DRAIN, PUT.
REQ-021 IDLE: start=1 SHALL latch com_len/dat_len and go to COM if com_len!=0, else RUN if dat_len!=0, else DRAIN.
REQ-022 start SHALL be ignored in every state other than IDLE.
REQ-023 get_ready SHALL be 1 in COM and RUN only, 0 otherwise.
REQ-024 com SHALL be 1 exactly in COM; run SHALL be 1 exactly in RUN.
REQ-025 get_c SHALL equal get_valid & get_ready & com (combinational); get_v SHALL equal get_valid & get_ready & run & ~com.
REQ-026 COM: a beat counter SHALL increment per get_c; on the get_c that makes count==com_len, the next state SHALL be RUN (dat_len!=0) or DRAIN (dat_len==0), and the counter SHALL clear.
REQ-027 RUN: the counter SHALL increment per get_v; on the get_v that makes count==dat_len, the next state SHALL be DRAIN.
REQ-028 Counter SHALL be max(COM_LEN_W,DAT_LEN_W) bits; a maximum length (all ones) SHALL complete without wrap.
REQ-029 exec SHALL be a register equal to get_v of the previous cycle (latency 1), forced 0 in IDLE.
REQ-030 DRAIN SHALL last exactly DRAIN_CYC cycles, then go to PUT.
REQ-031 PUT: put_valid SHALL be 1 and held until put_ready=1; that cycle SHALL move to IDLE.
REQ-032 done SHALL be 1 for exactly the cycle after the put_valid & put_ready handshake.
REQ-033 get_valid gaps SHALL stall the counter with no state change.
REQ-034 put_ready asserted before put_valid SHALL have no effect.

Reset
REQ-035 rst=1 SHALL immediately force state IDLE, counter 0, latched lengths 0, exec 0, done 0, regardless of the current phase.
REQ-036 While in reset and in IDLE, every output SHALL be 0.
REQ-037 After rst deasserts, the first start SHALL begin a clean job with no leftover beats.

Structure
REQ-038 State enum (IDLE, COM, RUN, DRAIN, PUT) and default length widths SHALL live in the shared package hpu_pkg.
REQ-039 The beat/drain counter SHALL be the sub-module beat_counter (clear, enable, terminal-count compare).

Verification
REQ-040 com_len=2, dat_len=3, get_valid held 1 -> get_c 2 cycles, get_v 3 cycles, exec 3 cycles lagging by 1, DRAIN 4 cycles, put_valid, done pulse.
REQ-041 com_len=0, dat_len=0 -> IDLE->DRAIN directly, get_ready never 1, put_valid after 4 cycles.
REQ-042 dat_len=5 with get_valid toggling 1,0,1,0 -> exactly 5 get_v, RUN spans 9 cycles.
REQ-043 put_ready held 0 for 10 cycles in PUT -> put_valid stays 1, done stays 0; on put_ready=1 -> done next cycle.
REQ-044 rst pulsed mid-RUN after 2 of 5 beats -> all outputs 0 immediately; new start with dat_len=1 -> exactly 1 get_v.
REQ-045 start re-pulsed during COM/RUN -> ignored, lengths unchanged, job completes normally.
